// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: op codes,
// SRAM size codes, FSM states and alignment helpers.
package mem_access_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LBU = 3'd1,
      OP_LH  = 3'd2,
      OP_LHU = 3'd3,
      OP_LW  = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } mem_op_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic size_t op_size(input mem_op_t op);
      size_t sz;
      unique case (op)
         OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
         default:              sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic misaligned(
      input mem_op_t    op,
      input logic [1:0] lo
   );
      logic bad;
      unique case (op_size(op))
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = |lo;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-SRAM request/response bus between the memory stage
// and the data memory.
interface mem_access_if;

   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req,
      output data_wr,
      output data_size,
      output data_addr,
      output data_wdata,
      output data_wstrb,
      input  data_addr_ok,
      input  data_data_ok,
      input  data_rdata
   );

   modport slave (
      input  data_req,
      input  data_wr,
      input  data_size,
      input  data_addr,
      input  data_wdata,
      input  data_wstrb,
      output data_addr_ok,
      output data_data_ok,
      output data_rdata
   );

endinterface

// File: rtl/mem_align.sv
// Store strobe/data replication and load byte/half extraction
// with sign or zero extension.
module mem_align
   import mem_access_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output size_t       size,
   output logic [3:0]  wstrb,
   output logic [31:0] store_data,
   output logic [31:0] load_data
);

   logic [31:0] shifted;
   logic [15:0] half;

   assign shifted = rdata >> {lo, 3'b000};
   assign half    = lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      size       = op_size(op);
      wstrb      = 4'b0000;
      store_data = wdata;
      load_data  = rdata;
      unique case (op)
         OP_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         OP_LBU: load_data = {24'h0, shifted[7:0]};
         OP_LH:  load_data = {{16{half[15]}}, half};
         OP_LHU: load_data = {16'h0, half};
         OP_LW:  load_data = rdata;
         OP_SB: begin
            wstrb      = 4'b0001 << lo;
            store_data = {4{wdata[7:0]}};
         end
         OP_SH: begin
            wstrb      = lo[1] ? 4'b1100 : 4'b0011;
            store_data = {2{wdata[15:0]}};
         end
         OP_SW:  wstrb = 4'b1111;
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one outstanding data-SRAM access at a
// time, with misalignment detection and flush cancellation.
module mem_access
   import mem_access_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [2:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_flush,
   input  logic        next_stall,
   output logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        mem_adel,
   output logic        mem_ades,
   mem_access_if.master dbus
);

   state_t      state;
   state_t      state_nx;
   mem_op_t     op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        wen_q;
   logic        cancel;
   logic        misal;
   logic        accept;
   logic        req;
   logic        capture;
   size_t       size;
   logic [31:0] load_data;

   assign misal  = misaligned(mem_op_t'(mem_op), mem_addr[1:0]);
   assign accept = (state == S_IDLE) & mem_valid
                 & (mem_ren | mem_wen) & !misal & !mem_flush;

   // a flushed or cancelled access still drains, but never updates
   assign capture = (state == S_DATA) & dbus.data_data_ok
                  & !cancel & !mem_flush & !wen_q;

   mem_align u_align (
      .op         (op_q),
      .lo         (addr_q[1:0]),
      .wdata      (wdata_q),
      .rdata      (dbus.data_rdata),
      .size       (size),
      .wstrb      (dbus.data_wstrb),
      .store_data (dbus.data_wdata),
      .load_data  (load_data)
   );

   assign dbus.data_req   = req;
   assign dbus.data_wr    = wen_q;
   assign dbus.data_size  = size;
   assign dbus.data_addr  = addr_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (accept) state_nx = S_ADDR;
         S_ADDR:
            if (dbus.data_addr_ok) state_nx = S_DATA;
            else if (mem_flush)    state_nx = S_IDLE;
         S_DATA:
            if (dbus.data_data_ok)
               state_nx = (cancel | mem_flush) ? S_IDLE : S_DONE;
         S_DONE:
            if (mem_flush | !next_stall) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      mem_stall = 1'b0;
      req       = 1'b0;
      mem_adel  = 1'b0;
      mem_ades  = 1'b0;
      unique case (state)
         S_IDLE: begin
            mem_stall = accept;
            mem_adel  = mem_valid & mem_ren & misal;
            mem_ades  = mem_valid & mem_wen & misal;
         end
         S_ADDR: begin
            mem_stall = 1'b1;
            req       = 1'b1;
         end
         S_DATA: mem_stall = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q    <= OP_LB;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wen_q   <= 1'b0;
      end else if (accept) begin
         op_q    <= mem_op_t'(mem_op);
         addr_q  <= mem_addr;
         wdata_q <= mem_wdata;
         wen_q   <= mem_wen;
      end
   end

   // flush racing addr_ok: the request is already accepted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cancel <= 1'b0;
      end else begin
         unique case (state)
            S_ADDR: cancel <= mem_flush & dbus.data_addr_ok;
            S_DATA:
               if (dbus.data_data_ok) cancel <= 1'b0;
               else if (mem_flush)    cancel <= 1'b1;
            default: cancel <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      mem_rdata <= 32'h0;
      else if (capture) mem_rdata <= load_data;
   end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed accesses with a
// scripted SRAM; monitors pop expected bus and result records.
module tb_mem_access;
   import mem_access_pkg::*;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      bit          chk_wd;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      int          len;
   } rd_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_ren, mem_wen;
   logic [2:0]  mem_op;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_flush, next_stall;
   logic        mem_stall, mem_adel, mem_ades;
   logic [31:0] mem_rdata;

   mem_access_if bus ();

   mem_access dut (
      .clk        (clk),
      .resetn     (resetn),
      .mem_valid  (mem_valid),
      .mem_ren    (mem_ren),
      .mem_wen    (mem_wen),
      .mem_op     (mem_op),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_flush  (mem_flush),
      .next_stall (next_stall),
      .mem_stall  (mem_stall),
      .mem_rdata  (mem_rdata),
      .mem_adel   (mem_adel),
      .mem_ades   (mem_ades),
      .dbus       (bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   req_t req_q[$];
   rd_t  rd_q[$];
   logic [31:0] exp_rdata = 32'h0;

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // bus monitor: every accepted request against the next record
   always @(negedge clk) begin
      if (resetn && bus.data_req && bus.data_addr_ok) begin
         if (req_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL req_unexpected: got addr %h expected none",
                     bus.data_addr);
         end else begin
            req_t r;
            r = req_q.pop_front();
            chk("req_wr", 32'(bus.data_wr), 32'(r.wr));
            chk("req_size", 32'(bus.data_size), 32'(r.size));
            chk("req_addr", bus.data_addr, r.addr);
            chk("req_strb", 32'(bus.data_wstrb), 32'(r.strb));
            if (r.chk_wd) chk("req_wdata", bus.data_wdata, r.wdata);
         end
      end
   end

   // result monitor: end of each stall burst
   int run = 0;
   always @(negedge clk) begin
      if (!resetn) begin
         run = 0;
      end else if (mem_stall) begin
         run++;
      end else if (run > 0) begin
         if (rd_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL rd_unexpected: got %h expected none",
                     mem_rdata);
         end else begin
            rd_t e;
            e = rd_q.pop_front();
            chk("rdata", mem_rdata, e.rdata);
            chk("stall_len", run, e.len);
         end
         run = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input mem_op_t op, input logic [31:0] a,
                           input logic [31:0] wd);
      tick();
      mem_valid = 1'b1;
      mem_op    = op;
      mem_ren   = (op < OP_SB);
      mem_wen   = (op >= OP_SB);
      mem_addr  = a;
      mem_wdata = wd;
      tick();
      mem_valid = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
   endtask

   task automatic sram(input int a_dly, input int d_dly,
                       input logic [31:0] rd,
                       input bit fl_addr, input bit fl_data);
      if (fl_addr) begin
         mem_flush = 1'b1;
         tick();
         mem_flush = 1'b0;
         return;
      end
      repeat (a_dly) tick();
      bus.data_addr_ok = 1'b1;
      tick();
      bus.data_addr_ok = 1'b0;
      for (int i = 0; i < d_dly; i++) begin
         mem_flush = fl_data && (i == 0);
         tick();
      end
      mem_flush = 1'b0;
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = rd;
      tick();
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = 32'h5A5A_5A5A;
   endtask

   task automatic load(input mem_op_t op, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] rd,
                       input logic [31:0] exp,
                       input int a_dly, input int d_dly);
      req_q.push_back('{1'b0, sz, a, 32'h0, 4'b0000, 1'b0});
      exp_rdata = exp;
      rd_q.push_back('{exp_rdata, 3 + a_dly + d_dly});
      drive_op(op, a, 32'h0);
      sram(a_dly, d_dly, rd, 1'b0, 1'b0);
   endtask

   task automatic store(input mem_op_t op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic [3:0] strb,
                        input logic [31:0] exp_wd, input int a_dly);
      req_q.push_back('{1'b1, sz, a, exp_wd, strb, 1'b1});
      rd_q.push_back('{exp_rdata, 3 + a_dly});
      drive_op(op, a, wd);
      sram(a_dly, 0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic misalign(input mem_op_t op, input logic [31:0] a,
                           input logic adel, input logic ades);
      tick();
      mem_valid = 1'b1;
      mem_op    = op;
      mem_ren   = (op < OP_SB);
      mem_wen   = (op >= OP_SB);
      mem_addr  = a;
      @(negedge clk);
      chk("adel", 32'(mem_adel), 32'(adel));
      chk("ades", 32'(mem_ades), 32'(ades));
      chk("misal_stall", 32'(mem_stall), 32'h0);
      tick();
      chk("misal_req", 32'(bus.data_req), 32'h0);
      mem_valid = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      mem_valid = 1'b0;
      mem_ren = 1'b0;
      mem_wen = 1'b0;
      mem_op = 3'd0;
      mem_addr = 32'h0;
      mem_wdata = 32'h0;
      mem_flush = 1'b0;
      next_stall = 1'b0;
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.data_rdata = 32'h0;
      repeat (3) tick();
      chk("rst_stall", 32'(mem_stall), 32'h0);
      chk("rst_req", 32'(bus.data_req), 32'h0);
      chk("rst_rdata", mem_rdata, 32'h0);
      resetn = 1'b1;
      tick();

      load(OP_LW,  32'h1000, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
      load(OP_LB,  32'h1003, 2'd0, 32'h80112233, 32'hFFFFFF80, 0, 1);
      load(OP_LBU, 32'h1003, 2'd0, 32'h80112233, 32'h00000080, 1, 0);
      load(OP_LH,  32'h1002, 2'd1, 32'h80112233, 32'hFFFF8011, 0, 0);
      load(OP_LHU, 32'h1000, 2'd1, 32'h1234F00D, 32'h0000F00D, 0, 2);
      load(OP_LB,  32'h1001, 2'd0, 32'h1234F07D, 32'h000000F0 |
                                                 32'hFFFFFF00, 0, 0);

      store(OP_SH, 32'h2002, 32'h0000ABCD, 2'd1, 4'b1100,
            32'hABCDABCD, 2);
      store(OP_SB, 32'h2001, 32'h12345677, 2'd0, 4'b0010,
            32'h77777777, 0);
      store(OP_SW, 32'h2004, 32'hCAFEF00D, 2'd2, 4'b1111,
            32'hCAFEF00D, 1);

      misalign(OP_LW, 32'h1001, 1'b1, 1'b0);
      misalign(OP_SW, 32'h1002, 1'b0, 1'b1);
      misalign(OP_LH, 32'h1003, 1'b1, 1'b0);

      // flush in IDLE blocks acceptance
      tick();
      mem_valid = 1'b1;
      mem_op = OP_LW;
      mem_ren = 1'b1;
      mem_addr = 32'h1000;
      mem_flush = 1'b1;
      @(negedge clk);
      chk("idle_flush_stall", 32'(mem_stall), 32'h0);
      tick();
      chk("idle_flush_req", 32'(bus.data_req), 32'h0);
      mem_valid = 1'b0;
      mem_ren = 1'b0;
      mem_flush = 1'b0;

      // flush in ADDR before addr_ok
      rd_q.push_back('{exp_rdata, 2});
      drive_op(OP_LW, 32'h3000, 32'h0);
      sram(0, 0, 32'h0, 1'b1, 1'b0);
      chk("addr_flush_req", 32'(bus.data_req), 32'h0);

      // flush in DATA, data_ok three cycles later
      req_q.push_back('{1'b0, 2'd2, 32'h3004, 32'h0, 4'b0000, 1'b0});
      rd_q.push_back('{exp_rdata, 6});
      drive_op(OP_LW, 32'h3004, 32'h0);
      sram(0, 3, 32'h11112222, 1'b0, 1'b1);
      chk("data_flush_rdata", mem_rdata, exp_rdata);

      // reset pulse in ADDR
      drive_op(OP_LW, 32'h4000, 32'h0);
      resetn = 1'b0;
      #1;
      chk("rst_addr_req", 32'(bus.data_req), 32'h0);
      @(negedge clk);
      tick();
      resetn = 1'b1;
      exp_rdata = 32'h0;
      bus.data_data_ok = 1'b1;
      bus.data_rdata = 32'hFFFFFFFF;
      tick();
      bus.data_data_ok = 1'b0;
      chk("stray_stall", 32'(mem_stall), 32'h0);
      chk("stray_req", 32'(bus.data_req), 32'h0);
      chk("stray_rdata", mem_rdata, exp_rdata);

      // next_stall holds DONE, then a normal load still works
      next_stall = 1'b1;
      load(OP_LW, 32'h5000, 2'd2, 32'h0BADF00D, 32'h0BADF00D, 0, 0);
      tick();
      chk("done_hold_stall", 32'(mem_stall), 32'h0);
      chk("done_hold_rdata", mem_rdata, 32'h0BADF00D);
      next_stall = 1'b0;
      load(OP_LH, 32'h5002, 2'd1, 32'h7FFF0000, 32'h00007FFF, 0, 0);

      repeat (3) tick();
      chk("req_q_left", req_q.size(), 32'h0);
      chk("rd_q_left", rd_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The module SHALL have ports: clk  in  1  sole clock, rising edge; resetn  in  1  asynchronous active-low reset.
REQ-002 The module SHALL have pipeline inputs: mem_valid in 1 instruction present; mem_ren in 1 load; mem_wen in 1 store; mem_op in 3 access type; mem_addr in 32 byte address; mem_wdata in 32 store data; mem_flush in 1 exception flush; next_stall in 1 downstream/global stall.
REQ-003 The module SHALL have data-SRAM ports: data_req out 1; data_wr out 1; data_size out 2 (0=byte, 1=half, 2=word); data_addr out 32; data_wdata out 32; data_wstrb out 4; data_addr_ok in 1; data_data_ok in 1; data_rdata in 32.
REQ-004 The module SHALL have result outputs: mem_stall out 1 freeze upstream; mem_rdata out 32 aligned, extended load data; mem_adel out 1 load misalign; mem_ades out 1 store misalign.

Function
REQ-005 mem_op SHALL encode LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-006 Misalignment: half access with addr[0]=1, or word access with addr[1:0]!=0, SHALL assert mem_adel (load) or mem_ades (store) combinationally in IDLE, issue no request, and hold mem_stall low.
REQ-007 FSM states SHALL be IDLE, ADDR, DATA, DONE.
REQ-008 IDLE: when mem_valid & (mem_ren|mem_wen) & aligned & !mem_flush, the module SHALL latch op/addr/wdata, assert mem_stall, and go to ADDR; otherwise it SHALL stay in IDLE with mem_stall low.
REQ-009 ADDR: data_req SHALL be 1, driven only from latched fields; on data_addr_ok go to DATA.
REQ-010 DATA: data_req SHALL be 0; on data_data_ok capture the extracted load data into the mem_rdata register and go to DONE.
REQ-011 DONE: mem_stall SHALL be 0 and mem_rdata valid; stay while next_stall=1, else go to IDLE.
REQ-012 mem_stall SHALL be 1 in the IDLE accept cycle, in ADDR and in DATA, and 0 otherwise; minimum access latency SHALL be 4 cycles (accept, ADDR, DATA, DONE).
REQ-013 Store encoding: SB wstrb=0001<<addr[1:0], wdata=byte x4; SH wstrb=0011 (addr[1]=0) or 1100, wdata=half x2; SW wstrb=1111, wdata unchanged; loads SHALL drive wstrb=0000.
REQ-014 Load extraction SHALL select the byte/half at addr[1:0] from data_rdata, sign-extend for LB/LH, and zero-extend for LBU/LHU; LW SHALL pass all 32 bits.
REQ-015 Flush in ADDR before data_addr_ok SHALL drop data_req next cycle and return to IDLE; if the flush coincides with data_addr_ok, the request counts as accepted.
REQ-016 Flush in DATA SHALL set a cancel flag; on data_data_ok the module SHALL go to IDLE, leaving mem_rdata unchanged.
REQ-017 Flush in DONE SHALL go to IDLE; flush in IDLE SHALL block acceptance.
REQ-018 data_data_ok outside DATA and data_addr_ok outside ADDR SHALL be ignored; at most one access SHALL be outstanding.

Reset
REQ-019 resetn low SHALL asynchronously force state=IDLE, the cancel flag and latched fields to 0, mem_rdata=0, and data_req=0.
REQ-020 Reset mid-access SHALL abandon the transaction; after reset, any in-flight data_data_ok SHALL be ignored per REQ-018.

Structure
REQ-021 The mem_op encodings, data_size codes and FSM state encodings SHALL live in the shared CPU definitions package/include.
REQ-022 Combinational store strobe/data replication and load extraction SHALL be one sub-module, mem_align; the FSM and registers SHALL stay in mem_access.

Verification
REQ-023 LW addr=0x1000, addr_ok and data_ok each in the first eligible cycle, rdata=0xDEADBEEF -> mem_stall high 3 cycles, DONE with mem_rdata=0xDEADBEEF.
REQ-024 LB addr=0x1003, rdata=0x80112233 -> mem_rdata=0xFFFFFF80; same access as LBU -> 0x00000080; LH addr=0x1002 -> 0xFFFF8011.
REQ-025 SH addr=0x2002, wdata=0x0000ABCD -> data_wr=1, wstrb=1100, data_wdata=0xABCDABCD, data_size=1.
REQ-026 LW addr=0x1001 -> mem_adel=1, data_req never asserted, mem_stall=0; SW addr=0x1002 -> mem_ades=1.
REQ-027 Flush in DATA with data_data_ok 3 cycles later -> mem_stall stays high until data_data_ok, FSM returns to IDLE, mem_rdata unchanged.
REQ-028 resetn pulsed low in ADDR -> data_req falls immediately; a later stray data_data_ok causes no state change.
